pipelined_barrel_shifter: RTL and testbench
===========================================

// Module: pipelined_barrel_shifter
// PURPOSE
//   Clocked, parametrised barrel shifter with valid/ready handshake on input and output.
//   Supports logical shift, arithmetic shift and rotate in either direction.
//   Implemented as log2(WIDTH) registered shift stages. Sits between a streaming data source
//   (e.g. switch/UART front end) and a consumer (LED driver, ALU datapath) that may apply backpressure.
// PARAMETERS
//   WIDTH   8   data width in bits; power of 2, >= 2
//   AMT_W   $clog2(WIDTH) (localparam)   shift-amount width and pipeline depth
// PORTS
//   clk         in   1       rising-edge clock
//   reset       in   1       asynchronous, active-high reset
//   in_valid    in   1       input beat present
//   in_ready    out  1       block accepts input this cycle
//   in_data     in   WIDTH   operand
//   in_amt      in   AMT_W   shift amount, 0..WIDTH-1
//   in_lr       in   1       1 = shift toward LSB (left-to-right); 0 = shift toward MSB
//   in_mode     in   2       00 logical, 01 arithmetic, 10 rotate, 11 reserved (= logical)
//   out_valid   out  1       result present
//   out_ready   in   1       consumer accepts result
//   out_data    out  WIDTH   shifted result
// BEHAVIOUR
//   - Reset (async assert, sync release): all stage valid bits 0; all stage data, amt, lr and mode regs 0.
//     Outputs: out_valid=0, out_data=0, in_ready=1.
//   - Global enable: en = ~out_valid | out_ready; in_ready = en (combinational, no in_valid dependency).
//   - Input accepted when in_valid & in_ready. While en=0 every stage holds data and valid unchanged.
//   - Stage k (k=0..AMT_W-1) shifts by 2^k when the carried amt bit k is 1, else passes through.
//     Stage k registers data, valid, amt, lr and mode on en.
//   - Latency: exactly AMT_W cycles from acceptance to out_valid under no backpressure.
//     Throughput: 1 beat/cycle.
//   - Bubbles (in_valid=0 while en=1) propagate as valid=0 slots. Stage data regs still load;
//     out_data is don't-care while out_valid=0.
//   - Fill rules:
//       logical:     vacated bits = 0.
//       arithmetic:  with lr=1, vacated bits = original MSB (carried sign); with lr=0, identical to logical.
//       rotate:      bits leaving one end re-enter at the other end.
//   - amt=0: out_data = in_data in every mode.
//   - Mode 11 behaves exactly as 00.
//   - Each beat carries its own amt/lr/mode; consecutive beats with different settings do not interact.
//   - out_data and out_valid stable while out_valid=1 & out_ready=0 (AXI-style hold).
//   - Reset mid-operation discards all in-flight beats; no partial result is ever emitted.
//   - No arithmetic overflow flagging; width never changes through the pipe.
// STRUCTURE
//   - Shared package shifter_pkg:
//       MODE_LOGICAL=2'b00, MODE_ARITH=2'b01, MODE_ROTATE=2'b10 constants;
//       LR_RIGHT=1'b1, LR_LEFT=1'b0.
//   - Sub-module barrel_shift_stage, params WIDTH and SHIFT (=2^k):
//       one combinational conditional shift plus a register slice for data, valid and control.
//       Instantiated AMT_W times via generate.
//   - Top level: en/ready logic, sign-bit capture at stage 0, generate loop, output assignment.
// TESTING (WIDTH=8, latency 3)
//   1. in_data=8'b11110000, lr=1, mode=00, amt=0..7 back-to-back, out_ready=1
//        -> 8'hF0,78,3C,1E,0F,07,03,01, one per cycle starting 3 cycles after first accept.
//   2. Same data, lr=1, mode=01, amt=3 -> 8'b11111110; data 8'b01110000, amt=3 -> 8'b00001110.
//   3. lr=0, mode=10, data 8'b11110000, amt=5 -> 8'b00011110;
//        lr=1, mode=10, amt=1 -> 8'b01111000; lr=0, mode=00, amt=7 -> 8'b00000000.
//   4. Backpressure: stream 5 beats, hold out_ready=0 for 6 cycles after first out_valid
//        -> in_ready=0, out_data/out_valid frozen.
//        On release, all 5 results delivered in order, none lost or duplicated.
//   5. Assert reset with 3 beats in flight
//        -> out_valid=0 and out_data=0 immediately (async), in_ready=1.
//        First post-reset beat emerges with latency 3 and the correct value.
//   6. Scoreboard random run, 1000 beats, random amt/lr/mode/in_valid/out_ready
//        -> every result matches reference model, order preserved.

Source files
------------

// File: rtl/shifter_pkg.sv
// rtl/shifter_pkg.sv - shared mode and direction constants for the pipelined barrel shifter
//
// Purpose: encodings for the per-beat shift mode and shift direction, shared by
//          the top level, the stage slices and anything that drives them.
// Ports:   none (package).
package shifter_pkg;

  // Shift mode carried with every beat. 2'b11 is reserved and decodes as logical.
  localparam logic [1:0] MODE_LOGICAL = 2'b00;
  localparam logic [1:0] MODE_ARITH   = 2'b01;
  localparam logic [1:0] MODE_ROTATE  = 2'b10;

  // Direction: "right" moves bits toward the LSB, "left" toward the MSB.
  localparam logic LR_RIGHT = 1'b1;
  localparam logic LR_LEFT  = 1'b0;

endpackage

// File: rtl/barrel_shift_stage.sv
// rtl/barrel_shift_stage.sv - one registered conditional shift-by-SHIFT slice
//
// Purpose: shifts the incoming beat by SHIFT bit positions when the matching
//          amount bit is set, otherwise passes it through, then registers the
//          result together with the beat's valid and control fields.
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   en                     global pipeline advance; all registers hold when low
//   src_valid/data/amt/lr/mode/sign   beat arriving from the previous slice
//   dst_valid/data/amt/lr/mode/sign   registered beat for the next slice
module barrel_shift_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHIFT = 1,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             src_valid,
  input  logic [WIDTH-1:0] src_data,
  input  logic [AMT_W-1:0] src_amt,
  input  logic             src_lr,
  input  logic [1:0]       src_mode,
  input  logic             src_sign,
  output logic             dst_valid,
  output logic [WIDTH-1:0] dst_data,
  output logic [AMT_W-1:0] dst_amt,
  output logic             dst_lr,
  output logic [1:0]       dst_mode,
  output logic             dst_sign
);

  // Which bit of the carried amount this slice is responsible for.
  localparam int AMT_BIT = $clog2(SHIFT);

  logic [WIDTH-1:0] shifted;

  always_comb begin
    shifted = src_data;
    if (src_amt[AMT_BIT]) begin
      case (src_mode)
        MODE_ROTATE: begin
          if (src_lr == LR_RIGHT)
            shifted = {src_data[SHIFT-1:0], src_data[WIDTH-1:SHIFT]};
          else
            shifted = {src_data[WIDTH-1-SHIFT:0], src_data[WIDTH-1:WIDTH-SHIFT]};
        end
        MODE_ARITH: begin
          // Fill with the sign captured at the pipe entry, not the current MSB:
          // earlier slices have already replaced the MSB with fill bits, which
          // are the same value, but the captured copy keeps intent explicit.
          if (src_lr == LR_RIGHT)
            shifted = {{SHIFT{src_sign}}, src_data[WIDTH-1:SHIFT]};
          else
            shifted = {src_data[WIDTH-1-SHIFT:0], {SHIFT{1'b0}}};
        end
        default: begin
          // Logical, and the reserved encoding.
          if (src_lr == LR_RIGHT)
            shifted = {{SHIFT{1'b0}}, src_data[WIDTH-1:SHIFT]};
          else
            shifted = {src_data[WIDTH-1-SHIFT:0], {SHIFT{1'b0}}};
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dst_valid <= 1'b0;
      dst_data  <= '0;
      dst_amt   <= '0;
      dst_lr    <= 1'b0;
      dst_mode  <= 2'b00;
      dst_sign  <= 1'b0;
    end else if (en) begin
      // Data loads even for bubbles; only valid qualifies it downstream.
      dst_valid <= src_valid;
      dst_data  <= shifted;
      dst_amt   <= src_amt;
      dst_lr    <= src_lr;
      dst_mode  <= src_mode;
      dst_sign  <= src_sign;
    end
  end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// rtl/pipelined_barrel_shifter.sv - log2(WIDTH)-stage barrel shifter with valid/ready handshakes
//
// Purpose: logical / arithmetic / rotate shifts in either direction, one beat
//          per cycle, AMT_W cycles of latency, full-pipe stall on backpressure.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   input beat present
//   in_ready   block accepts input this cycle
//   in_data    operand
//   in_amt     shift amount, 0..WIDTH-1
//   in_lr      1 = toward LSB, 0 = toward MSB
//   in_mode    00 logical, 01 arithmetic, 10 rotate, 11 as logical
//   out_valid  result present
//   out_ready  consumer accepts result
//   out_data   shifted result
module pipelined_barrel_shifter
  import shifter_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic             in_lr,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  // Index 0 is the pipe entry; index k+1 is the output of slice k.
  logic             valid_s [AMT_W+1];
  logic [WIDTH-1:0] data_s  [AMT_W+1];
  logic [AMT_W-1:0] amt_s   [AMT_W+1];
  logic             lr_s    [AMT_W+1];
  logic [1:0]       mode_s  [AMT_W+1];
  logic             sign_s  [AMT_W+1];

  logic en;

  // The whole pipe advances together: it may move whenever the output slot
  // is empty or is being drained this cycle. No in_valid term, so in_ready
  // never depends combinationally on the producer.
  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  assign valid_s[0] = in_valid;
  assign data_s[0]  = in_data;
  assign amt_s[0]   = in_amt;
  assign lr_s[0]    = in_lr;
  assign mode_s[0]  = in_mode;
  assign sign_s[0]  = in_data[WIDTH-1];

  for (genvar k = 0; k < AMT_W; k++) begin : g_stage
    barrel_shift_stage #(
      .WIDTH (WIDTH),
      .SHIFT (1 << k),
      .AMT_W (AMT_W)
    ) u_stage (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .src_valid (valid_s[k]),
      .src_data  (data_s[k]),
      .src_amt   (amt_s[k]),
      .src_lr    (lr_s[k]),
      .src_mode  (mode_s[k]),
      .src_sign  (sign_s[k]),
      .dst_valid (valid_s[k+1]),
      .dst_data  (data_s[k+1]),
      .dst_amt   (amt_s[k+1]),
      .dst_lr    (lr_s[k+1]),
      .dst_mode  (mode_s[k+1]),
      .dst_sign  (sign_s[k+1])
    );
  end

  assign out_valid = valid_s[AMT_W];
  assign out_data  = data_s[AMT_W];

  // Control fields of the final slice have no consumer.
  logic unused_tail;
  assign unused_tail = ^{amt_s[AMT_W], lr_s[AMT_W], mode_s[AMT_W], sign_s[AMT_W]};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// tb/tb_pipelined_barrel_shifter.sv - self-checking bench for pipelined_barrel_shifter
module tb_pipelined_barrel_shifter;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_amt;
  logic       in_lr;
  logic [1:0] in_mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;

  always #5 clk = ~clk;

  pipelined_barrel_shifter #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_lr     (in_lr),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  typedef struct {
    logic [7:0] exp;
    int         cyc;
    bit         lat;
  } sb_t;

  typedef struct {
    logic [7:0] data;
    logic [2:0] amt;
    logic       lr;
    logic [1:0] mode;
    logic [7:0] exp;
  } vec_t;

  sb_t        sbq[$];
  vec_t       vt[16];
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  bit         chk_lat = 1'b0;
  bit         last_acc = 1'b0;
  logic [7:0] drv_exp = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Bit-by-bit reference, independent of the staged decomposition.
  function automatic logic [7:0] ref_shift(input logic [7:0] d, input logic [2:0] amt,
                                           input logic lr, input logic [1:0] mode);
    logic [7:0] r;
    int a;
    a = int'(amt);
    for (int i = 0; i < 8; i++) begin
      if (mode == 2'b10) begin
        r[i] = lr ? d[(i + a) % 8] : d[(i - a + 8) % 8];
      end else if (lr) begin
        if (i + a < 8) r[i] = d[i + a];
        else           r[i] = (mode == 2'b01) ? d[7] : 1'b0;
      end else begin
        r[i] = (i >= a) ? d[i - a] : 1'b0;
      end
    end
    return r;
  endfunction

  task automatic set_beat(input logic [7:0] d, input logic [2:0] a, input logic lr,
                          input logic [1:0] m, input logic [7:0] e);
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = a;
    in_lr    = lr;
    in_mode  = m;
    drv_exp  = e;
  endtask

  // Inputs are set just after a falling edge; sample #1 later, then advance
  // one clock and return at the next falling edge.
  task automatic cycle();
    sb_t e;
    #1;
    if (out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got %0h, expected no result (cycle %0d)", out_data, cyc);
      end else begin
        e = sbq.pop_front();
        check("out_data", {24'h0, out_data}, {24'h0, e.exp});
        if (e.lat) check("latency", cyc - e.cyc, 3);
      end
    end
    last_acc = in_valid && in_ready;
    if (last_acc) sbq.push_back('{drv_exp, cyc, chk_lat});
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (sbq.size() > 0 && n < 200) begin
      cycle();
      n++;
    end
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d results outstanding, expected 0", sbq.size());
      sbq.delete();
    end
    #1;
    check("idle_out_valid", {31'h0, out_valid}, 32'h0);
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] frozen;
    logic [7:0] bd[5];
    int         idx;
    int         n;
    int         sent;
    logic [7:0] rd;
    logic [2:0] ra;
    logic       rl;
    logic [1:0] rm;

    for (int i = 0; i < 8; i++) vt[i] = '{8'hF0, 3'(i), 1'b1, 2'b00, 8'h00};
    vt[0].exp = 8'hF0; vt[1].exp = 8'h78; vt[2].exp = 8'h3C; vt[3].exp = 8'h1E;
    vt[4].exp = 8'h0F; vt[5].exp = 8'h07; vt[6].exp = 8'h03; vt[7].exp = 8'h01;
    vt[8]  = '{8'hF0, 3'd3, 1'b1, 2'b01, 8'hFE};
    vt[9]  = '{8'h70, 3'd3, 1'b1, 2'b01, 8'h0E};
    vt[10] = '{8'hF0, 3'd5, 1'b0, 2'b10, 8'h1E};
    vt[11] = '{8'hF0, 3'd1, 1'b1, 2'b10, 8'h78};
    vt[12] = '{8'hF0, 3'd7, 1'b0, 2'b00, 8'h00};
    vt[13] = '{8'hB5, 3'd2, 1'b1, 2'b11, 8'h2D};
    vt[14] = '{8'h9C, 3'd4, 1'b0, 2'b01, 8'hC0};
    vt[15] = '{8'hA5, 3'd0, 1'b0, 2'b10, 8'hA5};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_amt    = 3'd0;
    in_lr     = 1'b0;
    in_mode   = 2'b00;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_out_valid", {31'h0, out_valid}, 32'h0);
    check("reset_out_data", {24'h0, out_data}, 32'h0);
    check("reset_in_ready", {31'h0, in_ready}, 32'h1);
    reset = 1'b0;
    @(negedge clk);

    // Table vectors back-to-back, no backpressure, latency checked.
    chk_lat = 1'b1;
    for (int i = 0; i < 16; i++) begin
      set_beat(vt[i].data, vt[i].amt, vt[i].lr, vt[i].mode, vt[i].exp);
      cycle();
    end
    drain();

    // Backpressure: stall output until pipe is full, hold 6 cycles, release.
    chk_lat = 1'b0;
    for (int i = 0; i < 5; i++) bd[i] = 8'h93 + 8'(i * 37);
    out_ready = 1'b0;
    idx = 0;
    n = 0;
    #1;
    while (!out_valid && n < 20) begin
      if (idx < 5) set_beat(bd[idx], 3'(idx + 1), idx[0], 2'(idx % 3),
                            ref_shift(bd[idx], 3'(idx + 1), idx[0], 2'(idx % 3)));
      else in_valid = 1'b0;
      cycle();
      if (last_acc) idx++;
      n++;
      #1;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL bp_fill_timeout: got out_valid=0, expected 1");
    end
    frozen = out_data;
    for (int s = 0; s < 6; s++) begin
      if (idx < 5) set_beat(bd[idx], 3'(idx + 1), idx[0], 2'(idx % 3),
                            ref_shift(bd[idx], 3'(idx + 1), idx[0], 2'(idx % 3)));
      #1;
      check("bp_in_ready", {31'h0, in_ready}, 32'h0);
      check("bp_out_valid", {31'h0, out_valid}, 32'h1);
      check("bp_out_data", {24'h0, out_data}, {24'h0, frozen});
      cycle();
      if (last_acc) idx++;
    end
    out_ready = 1'b1;
    n = 0;
    while (idx < 5 && n < 50) begin
      set_beat(bd[idx], 3'(idx + 1), idx[0], 2'(idx % 3),
               ref_shift(bd[idx], 3'(idx + 1), idx[0], 2'(idx % 3)));
      cycle();
      if (last_acc) idx++;
      n++;
    end
    check("bp_all_sent", idx, 5);
    drain();

    // Reset with three beats in flight.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_beat(8'hC3, 3'(i + 1), 1'b1, 2'b01, ref_shift(8'hC3, 3'(i + 1), 1'b1, 2'b01));
      cycle();
    end
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("midreset_out_valid", {31'h0, out_valid}, 32'h0);
    check("midreset_out_data", {24'h0, out_data}, 32'h0);
    check("midreset_in_ready", {31'h0, in_ready}, 32'h1);
    sbq.delete();
    @(negedge clk);
    reset = 1'b0;
    chk_lat = 1'b1;
    set_beat(8'h81, 3'd1, 1'b1, 2'b01, 8'hC0);
    cycle();
    drain();

    // Random scoreboard run.
    chk_lat = 1'b0;
    sent = 0;
    n = 0;
    while (sent < 1000 && n < 20000) begin
      rd = 8'($urandom);
      ra = 3'($urandom_range(0, 7));
      rl = 1'($urandom_range(0, 1));
      rm = 2'($urandom_range(0, 3));
      set_beat(rd, ra, rl, rm, ref_shift(rd, ra, rl, rm));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
      if (last_acc) sent++;
      n++;
    end
    check("random_beats_sent", sent, 1000);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
